qsim_job_ctrl: RTL and testbench



---
 rtl/qsim_pkg.sv | 19 +
 rtl/qsim_res_fifo.sv | 76 +++++++
 rtl/qsim_job_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_qsim_job_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/qsim_pkg.sv
// Shared defaults and the result record for the amplitude-job controller.
package qsim_pkg;

  localparam int QW_DEF        = 16;
  localparam int DW_DEF        = 5;
  localparam int AW_DEF        = 13;
  localparam int PW_DEF        = 7;
  localparam int TAGW_DEF      = 2;
  localparam int RES_DEPTH_DEF = 8;
  localparam int TIMEOUT_DEF   = 4096;

  typedef struct packed {
    logic        [TAGW_DEF-1:0] tag;
    logic signed [AW_DEF-1:0]   re;
    logic signed [AW_DEF-1:0]   im;
    logic        [PW_DEF-1:0]   ptr;
  } qsim_res_t;

endpackage

// File: rtl/qsim_res_fifo.sv
// First-word-fall-through result FIFO with occupancy and next-occupancy outputs.
module qsim_res_fifo
  import qsim_pkg::*;
#(
  parameter  int W     = 8,
  parameter  int DEPTH = RES_DEPTH_DEF,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic [CW-1:0] count_nxt,
  output logic          push_acc
);

  localparam int PTRW = $clog2(DEPTH);

  logic [W-1:0]    mem_q [DEPTH];
  logic [W-1:0]    mem_d [DEPTH];
  logic [PTRW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pop_ok, push_ok;

  always_comb begin
    pop_ok  = pop && (cnt_q != {CW{1'b0}});
    // A full FIFO still takes a push when the head leaves in the same cycle.
    push_ok = push && ((cnt_q != CW'(DEPTH)) || pop_ok);
    mem_d   = mem_q;
    if (push_ok) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + 1'b1;
    end else begin
      wr_d = wr_q;
    end
    if (pop_ok) begin
      rd_d = rd_q + 1'b1;
    end else begin
      rd_d = rd_q;
    end
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= {W{1'b0}};
      rd_q  <= {PTRW{1'b0}};
      wr_q  <= {PTRW{1'b0}};
      cnt_q <= {CW{1'b0}};
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= {W{1'b0}};
      rd_q  <= {PTRW{1'b0}};
      wr_q  <= {PTRW{1'b0}};
      cnt_q <= {CW{1'b0}};
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout      = mem_q[rd_q];
  assign count     = cnt_q;
  assign count_nxt = cnt_d;
  assign push_acc  = push_ok;

endmodule

// File: rtl/qsim_job_ctrl.sv
// Multi-outstanding amplitude job controller: tags and issues jobs, matches
// tagged replies, queues results and raises sticky tag/watchdog errors.
module qsim_job_ctrl
  import qsim_pkg::*;
#(
  parameter int QW        = QW_DEF,
  parameter int DW        = DW_DEF,
  parameter int AW        = AW_DEF,
  parameter int PW        = PW_DEF,
  parameter int TAGW      = TAGW_DEF,
  parameter int RES_DEPTH = RES_DEPTH_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 soft_clr,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [QW-1:0]        cmd_target,
  input  logic [QW-1:0]        cmd_initial,
  input  logic [DW-1:0]        cmd_depth,
  output logic                 wu_valid,
  input  logic                 wu_ready,
  output logic [QW-1:0]        wu_target,
  output logic [QW-1:0]        wu_initial,
  output logic [DW-1:0]        wu_depth,
  output logic [TAGW-1:0]      wu_tag,
  input  logic                 rsp_valid,
  input  logic [TAGW-1:0]      rsp_tag,
  input  logic signed [AW-1:0] rsp_real,
  input  logic signed [AW-1:0] rsp_imag,
  input  logic [PW-1:0]        rsp_ptr,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [TAGW-1:0]      res_tag,
  output logic signed [AW-1:0] res_real,
  output logic signed [AW-1:0] res_imag,
  output logic [PW-1:0]        res_ptr,
  output logic [TAGW:0]        outstanding,
  output logic                 busy,
  output logic                 err_timeout,
  output logic                 err_tag
);

  localparam int MAX_OUT = 2 ** TAGW;
  localparam int RW      = TAGW + 2 * AW + PW;
  localparam int CW      = $clog2(RES_DEPTH) + 1;
  localparam int WDW     = $clog2(TIMEOUT) + 1;

  logic               wu_valid_q, wu_valid_d;
  logic [QW-1:0]      wu_target_q, wu_target_d, wu_initial_q, wu_initial_d;
  logic [DW-1:0]      wu_depth_q, wu_depth_d;
  logic [TAGW-1:0]    wu_tag_q, wu_tag_d, next_tag_q, next_tag_d;
  logic [MAX_OUT-1:0] inflight_q, inflight_d;
  logic [TAGW:0]      outstanding_q, outstanding_d;
  logic [WDW-1:0]     wd_q, wd_d;
  logic               err_timeout_q, err_timeout_d, err_tag_q, err_tag_d;
  logic               cmd_ready_q, cmd_ready_d, busy_q, busy_d;

  logic               cmd_acc, wu_hs, rsp_known, res_pop, push_acc;
  logic [CW-1:0]      fifo_count, fifo_count_nxt;
  logic [RW-1:0]      fifo_dout;

  assign res_valid = (fifo_count != {CW{1'b0}});
  assign res_pop   = res_valid && res_ready;

  qsim_res_fifo #(.W(RW), .DEPTH(RES_DEPTH)) u_res_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (soft_clr),
    .push      (rsp_known),
    .din       ({rsp_tag, rsp_real, rsp_imag, rsp_ptr}),
    .pop       (res_pop),
    .dout      (fifo_dout),
    .count     (fifo_count),
    .count_nxt (fifo_count_nxt),
    .push_acc  (push_acc)
  );

  always_comb begin
    cmd_acc   = cmd_valid && cmd_ready_q;
    wu_hs     = wu_valid_q && wu_ready;
    // Looks at the pre-edge bitmap, so a reply to the tag issuing now is unknown.
    rsp_known = rsp_valid && inflight_q[rsp_tag];

    wu_target_d  = wu_target_q;
    wu_initial_d = wu_initial_q;
    wu_depth_d   = wu_depth_q;
    wu_tag_d     = wu_tag_q;
    if (cmd_acc) begin
      wu_target_d  = cmd_target;
      wu_initial_d = cmd_initial;
      wu_depth_d   = cmd_depth;
      wu_tag_d     = next_tag_q;
      wu_valid_d   = 1'b1;
    end else if (wu_hs) begin
      wu_valid_d = 1'b0;
    end else begin
      wu_valid_d = wu_valid_q;
    end

    next_tag_d = wu_hs ? next_tag_q + 1'b1 : next_tag_q;

    inflight_d = inflight_q;
    if (wu_hs) begin
      inflight_d[wu_tag_q] = 1'b1;
    end else begin
      inflight_d = inflight_q;
    end
    if (rsp_known) begin
      inflight_d[rsp_tag] = 1'b0;
    end else begin
      inflight_d = inflight_d;
    end

    case ({wu_hs, rsp_known})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase

    if ((outstanding_q == {(TAGW+1){1'b0}}) || rsp_known) begin
      wd_d = {WDW{1'b0}};
    end else if (!rsp_valid && (wd_q != WDW'(TIMEOUT - 1))) begin
      wd_d = wd_q + 1'b1;
    end else begin
      wd_d = wd_q;
    end

    err_timeout_d = err_timeout_q || (wd_d == WDW'(TIMEOUT - 1));
    err_tag_d     = err_tag_q || (rsp_valid && !inflight_q[rsp_tag]) || (rsp_known && !push_acc);

    // Ready is registered from next-state values so it reflects the post-edge state.
    cmd_ready_d = !wu_valid_d && !inflight_d[next_tag_d] && !err_timeout_d &&
                  ((int'(fifo_count_nxt) + int'(outstanding_d)) < RES_DEPTH);
    busy_d      = (outstanding_d != {(TAGW+1){1'b0}}) || wu_valid_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wu_valid_q    <= 1'b0;
      wu_target_q   <= {QW{1'b0}};
      wu_initial_q  <= {QW{1'b0}};
      wu_depth_q    <= {DW{1'b0}};
      wu_tag_q      <= {TAGW{1'b0}};
      next_tag_q    <= {TAGW{1'b0}};
      inflight_q    <= {MAX_OUT{1'b0}};
      outstanding_q <= {(TAGW+1){1'b0}};
      wd_q          <= {WDW{1'b0}};
      err_timeout_q <= 1'b0;
      err_tag_q     <= 1'b0;
      cmd_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else if (soft_clr) begin
      wu_valid_q    <= 1'b0;
      wu_target_q   <= {QW{1'b0}};
      wu_initial_q  <= {QW{1'b0}};
      wu_depth_q    <= {DW{1'b0}};
      wu_tag_q      <= {TAGW{1'b0}};
      next_tag_q    <= {TAGW{1'b0}};
      inflight_q    <= {MAX_OUT{1'b0}};
      outstanding_q <= {(TAGW+1){1'b0}};
      wd_q          <= {WDW{1'b0}};
      err_timeout_q <= 1'b0;
      err_tag_q     <= 1'b0;
      cmd_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      wu_valid_q    <= wu_valid_d;
      wu_target_q   <= wu_target_d;
      wu_initial_q  <= wu_initial_d;
      wu_depth_q    <= wu_depth_d;
      wu_tag_q      <= wu_tag_d;
      next_tag_q    <= next_tag_d;
      inflight_q    <= inflight_d;
      outstanding_q <= outstanding_d;
      wd_q          <= wd_d;
      err_timeout_q <= err_timeout_d;
      err_tag_q     <= err_tag_d;
      cmd_ready_q   <= cmd_ready_d;
      busy_q        <= busy_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign wu_valid    = wu_valid_q;
  assign wu_target   = wu_target_q;
  assign wu_initial  = wu_initial_q;
  assign wu_depth    = wu_depth_q;
  assign wu_tag      = wu_tag_q;
  assign outstanding = outstanding_q;
  assign busy        = busy_q;
  assign err_timeout = err_timeout_q;
  assign err_tag     = err_tag_q;
  assign {res_tag, res_real, res_imag, res_ptr} = fifo_dout;

endmodule

// File: tb/tb_qsim_job_ctrl.sv
// Randomised and directed bench for qsim_job_ctrl against a queue-based job/result model.
module tb_qsim_job_ctrl;
  import qsim_pkg::*;

  localparam int QW = 16, DW = 5, AW = 13, PW = 7, TAGW = 2;
  localparam int MAX_OUT = 4, RES_DEPTH = 8, TIMEOUT = 4096;

  logic clk = 1'b0, rst = 1'b1, soft_clr = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [QW-1:0] cmd_target = '0, cmd_initial = '0;
  logic [DW-1:0] cmd_depth = '0;
  logic wu_valid, wu_ready = 1'b0;
  logic [QW-1:0] wu_target, wu_initial;
  logic [DW-1:0] wu_depth;
  logic [TAGW-1:0] wu_tag;
  logic rsp_valid = 1'b0;
  logic [TAGW-1:0] rsp_tag = '0;
  logic signed [AW-1:0] rsp_real = '0, rsp_imag = '0;
  logic [PW-1:0] rsp_ptr = '0;
  logic res_valid, res_ready = 1'b0;
  logic [TAGW-1:0] res_tag;
  logic signed [AW-1:0] res_real, res_imag;
  logic [PW-1:0] res_ptr;
  logic [TAGW:0] outstanding;
  logic busy, err_timeout, err_tag;

  qsim_job_ctrl #(.QW(QW), .DW(DW), .AW(AW), .PW(PW), .TAGW(TAGW),
                  .RES_DEPTH(RES_DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .soft_clr(soft_clr),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_target(cmd_target),
    .cmd_initial(cmd_initial), .cmd_depth(cmd_depth),
    .wu_valid(wu_valid), .wu_ready(wu_ready), .wu_target(wu_target),
    .wu_initial(wu_initial), .wu_depth(wu_depth), .wu_tag(wu_tag),
    .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_real(rsp_real),
    .rsp_imag(rsp_imag), .rsp_ptr(rsp_ptr),
    .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag),
    .res_real(res_real), .res_imag(res_imag), .res_ptr(res_ptr),
    .outstanding(outstanding), .busy(busy), .err_timeout(err_timeout), .err_tag(err_tag)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: job slot, set of tags in flight, result queue, sticky errors.
  bit            m_slot, m_fresh, m_err_tag, m_err_to;
  logic [QW-1:0] m_tgt, m_ini;
  logic [DW-1:0] m_dep;
  int            m_slot_tag, m_next, m_nout, m_idle;
  bit            m_inf [MAX_OUT];
  qsim_res_t     m_q [$];

  function automatic void model_reset();
    m_slot = 0; m_fresh = 1; m_err_tag = 0; m_err_to = 0;
    m_next = 0; m_nout = 0; m_idle = 0; m_slot_tag = 0;
    for (int i = 0; i < MAX_OUT; i++) m_inf[i] = 0;
    m_q.delete();
  endfunction

  function automatic bit exp_ready();
    return !m_slot && !m_inf[m_next] && (m_q.size() + m_nout < RES_DEPTH) && !m_err_to && !m_fresh;
  endfunction

  task automatic cycle();
    bit acc, hs, known, pop;
    qsim_res_t r;
    @(negedge clk);
    chk_eq("cmd_ready", cmd_ready, exp_ready());
    chk_eq("wu_valid", wu_valid, m_slot);
    if (m_slot) begin
      chk_eq("wu_tag", wu_tag, m_slot_tag);
      chk_eq("wu_target", wu_target, m_tgt);
      chk_eq("wu_initial", wu_initial, m_ini);
      chk_eq("wu_depth", wu_depth, m_dep);
    end
    chk_eq("outstanding", outstanding, m_nout);
    chk_eq("busy", busy, (m_nout != 0) || m_slot);
    chk_eq("res_valid", res_valid, m_q.size() != 0);
    chk_eq("err_tag", err_tag, m_err_tag);
    chk_eq("err_timeout", err_timeout, m_err_to);
    if (m_q.size() != 0) begin
      chk_eq("res_tag", res_tag, m_q[0].tag);
      chk_eq("res_real", res_real, m_q[0].re);
      chk_eq("res_imag", res_imag, m_q[0].im);
      chk_eq("res_ptr", res_ptr, m_q[0].ptr);
    end
    acc   = cmd_valid && exp_ready();
    hs    = m_slot && wu_ready;
    known = rsp_valid && m_inf[rsp_tag];
    pop   = (m_q.size() != 0) && res_ready;
    if (soft_clr) model_reset();
    else begin
      m_fresh = 0;
      if (m_nout == 0 || known) m_idle = 0;
      else if (!rsp_valid && m_idle < TIMEOUT - 1) m_idle++;
      if (m_idle == TIMEOUT - 1) m_err_to = 1;
      if (pop) void'(m_q.pop_front());
      if (rsp_valid && known) begin
        m_inf[rsp_tag] = 0; m_nout--;
        r.tag = rsp_tag; r.re = rsp_real; r.im = rsp_imag; r.ptr = rsp_ptr;
        if (m_q.size() < RES_DEPTH) m_q.push_back(r); else m_err_tag = 1;
      end else if (rsp_valid) m_err_tag = 1;
      if (hs) begin m_inf[m_slot_tag] = 1; m_nout++; m_next = (m_next + 1) % MAX_OUT; m_slot = 0; end
      if (acc) begin m_slot = 1; m_tgt = cmd_target; m_ini = cmd_initial; m_dep = cmd_depth; m_slot_tag = m_next; end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_cmd_fields();
    cmd_target = QW'($urandom); cmd_initial = QW'($urandom); cmd_depth = DW'($urandom);
  endtask

  task automatic send_cmd(input logic [QW-1:0] t, input logic [QW-1:0] i, input logic [DW-1:0] d);
    bit done = 0;
    cmd_target = t; cmd_initial = i; cmd_depth = d; cmd_valid = 1;
    for (int k = 0; k < 50 && !done; k++) begin
      done = exp_ready();
      cycle();
    end
    cmd_valid = 0;
    chk_eq("send_cmd_accepted", done, 1'b1);
  endtask

  task automatic reply(input int t, input int re, input int im, input int p);
    rsp_valid = 1; rsp_tag = TAGW'(t); rsp_real = AW'(re); rsp_imag = AW'(im); rsp_ptr = PW'(p);
    cycle();
    rsp_valid = 0;
  endtask

  task automatic drain();
    cmd_valid = 0; res_ready = 1; wu_ready = 1;
    for (int k = 0; k < 60; k++) begin
      rsp_valid = 0;
      for (int t = 0; t < MAX_OUT; t++)
        if (m_inf[t] && !rsp_valid) begin
          rsp_valid = 1; rsp_tag = TAGW'(t);
          rsp_real = AW'($urandom); rsp_imag = AW'($urandom); rsp_ptr = PW'($urandom);
        end
      cycle();
    end
    rsp_valid = 0; res_ready = 0;
    chk_eq("drain_outstanding", outstanding, 3'd0);
    chk_eq("drain_res_valid", res_valid, 1'b0);
  endtask

  task automatic chk_all_zero(input string p);
    chk_eq({p, ".cmd_ready"}, cmd_ready, 1'b0);   chk_eq({p, ".wu_valid"}, wu_valid, 1'b0);
    chk_eq({p, ".wu_target"}, wu_target, 16'd0);  chk_eq({p, ".wu_initial"}, wu_initial, 16'd0);
    chk_eq({p, ".wu_depth"}, wu_depth, 5'd0);     chk_eq({p, ".wu_tag"}, wu_tag, 2'd0);
    chk_eq({p, ".res_valid"}, res_valid, 1'b0);   chk_eq({p, ".res_tag"}, res_tag, 2'd0);
    chk_eq({p, ".res_real"}, res_real, 13'd0);    chk_eq({p, ".res_imag"}, res_imag, 13'd0);
    chk_eq({p, ".res_ptr"}, res_ptr, 7'd0);       chk_eq({p, ".outstanding"}, outstanding, 3'd0);
    chk_eq({p, ".busy"}, busy, 1'b0);             chk_eq({p, ".err_timeout"}, err_timeout, 1'b0);
    chk_eq({p, ".err_tag"}, err_tag, 1'b0);
  endtask

  task automatic pulse_soft_clr();
    soft_clr = 1; cycle(); soft_clr = 0; cycle();
  endtask

  initial begin
    model_reset();
    #12;
    chk_all_zero("reset");
    @(posedge clk); #1; rst = 0;
    repeat (2) cycle();

    // Single job, reply after 10 cycles.
    wu_ready = 1;
    send_cmd(16'h0003, 16'h0000, 5'd4);
    chk_eq("single_wu_tag", wu_tag, 2'd0);
    repeat (10) cycle();
    chk_eq("single_out1", outstanding, 3'd1);
    reply(0, -5, 7, 3);
    chk_eq("single_res_real", res_real, -13'sd5);
    chk_eq("single_res_imag", res_imag, 13'sd7);
    chk_eq("single_res_ptr", res_ptr, 7'd3);
    chk_eq("single_out0", outstanding, 3'd0);
    chk_eq("single_busy", busy, 1'b0);
    res_ready = 1; cycle(); res_ready = 0; cycle();

    // Fill all tags, then out-of-order replies 3,1,0,2 with a command waiting.
    cmd_valid = 1;
    for (int k = 0; k < 12; k++) begin rand_cmd_fields(); cycle(); end
    chk_eq("fill_out4", outstanding, 3'd4);
    chk_eq("fill_ready_low", cmd_ready, 1'b0);
    reply(3, 100, -100, 1); cycle();
    reply(1, -4096, 4095, 2); cycle();
    chk_eq("ooo_tag0_blocks", cmd_ready, 1'b0);
    reply(0, 1, -1, 3); cycle();
    reply(2, 17, 33, 4);
    repeat (4) cycle();
    cmd_valid = 0;
    res_ready = 1; repeat (6) cycle(); res_ready = 0;
    drain();

    // Issue backpressure: slot must hold while command fields keep changing.
    wu_ready = 0; cmd_valid = 1;
    for (int k = 0; k < 22; k++) begin rand_cmd_fields(); cycle(); end
    wu_ready = 1;
    // Result backpressure: replies flow in but nobody pops.
    for (int k = 0; k < 40; k++) begin
      rand_cmd_fields();
      rsp_valid = 0;
      for (int t = 0; t < MAX_OUT; t++)
        if (m_inf[t] && !rsp_valid) begin
          rsp_valid = 1; rsp_tag = TAGW'(t); rsp_real = AW'($urandom);
          rsp_imag = AW'($urandom); rsp_ptr = PW'($urandom);
        end
      cycle();
    end
    rsp_valid = 0;
    chk_eq("bp_fifo_full_ready", cmd_ready, 1'b0);
    chk_eq("bp_res_valid", res_valid, 1'b1);
    drain();

    // Unknown-tag reply, then watchdog expiry.
    pulse_soft_clr();
    reply(1, 5, 5, 5);
    cycle();
    chk_eq("unknown_err_tag", err_tag, 1'b1);
    chk_eq("unknown_fifo", res_valid, 1'b0);
    pulse_soft_clr();
    send_cmd(16'h1234, 16'h0042, 5'd9);
    cmd_valid = 1;
    repeat (TIMEOUT + 10) cycle();
    chk_eq("to_err", err_timeout, 1'b1);
    chk_eq("to_ready", cmd_ready, 1'b0);
    reply(0, 9, 9, 9);
    cmd_valid = 0;
    cycle();
    pulse_soft_clr();
    chk_eq("to_cleared", err_timeout, 1'b0);

    // Asynchronous reset with two jobs in flight, then a late reply.
    wu_ready = 1;
    send_cmd(16'hAAAA, 16'h5555, 5'd1);
    send_cmd(16'hBBBB, 16'h6666, 5'd2);
    cycle();
    @(posedge clk); #3; rst = 1; #1;
    chk_all_zero("arst");
    @(posedge clk); #1; rst = 0; model_reset();
    cycle();
    reply(0, 1, 2, 3);
    chk_eq("late_reply_err_tag", err_tag, 1'b1);
    pulse_soft_clr();

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      int r;
      cmd_valid = ($urandom % 2) == 0;
      rand_cmd_fields();
      wu_ready  = ($urandom % 4) != 0;
      res_ready = ($urandom % 3) != 0;
      soft_clr  = ($urandom % 600) == 0;
      r = $urandom % 8;
      rsp_tag = TAGW'($urandom);
      rsp_valid = (r < 4 && m_inf[rsp_tag]) || (r == 7 && ($urandom % 20) == 0);
      rsp_real = AW'($urandom); rsp_imag = AW'($urandom); rsp_ptr = PW'($urandom);
      cycle();
    end
    soft_clr = 0; rsp_valid = 0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
